ethernet_reply_stream_tx: RTL and testbench
===========================================

# ethernet_reply_stream_tx

Parametrised reply-frame serializer for the Ethernet reply path. It accepts one pre-built reply (fixed-length header plus variable-length payload) per handshake. It emits the reply as a byte-lane stream, BEAT_BYTES bytes per beat, with valid/ready backpressure, a per-beat keep mask and an end-of-frame marker. It sits between the reply builders (ICMP/ARP) and the MAC TX interface. It replaces the single-byte, no-backpressure ICMP transmitter.

## Interface
- HEAD_BYTES, 42, header length in bytes (Ethernet+IP+ICMP header).
- MAX_PAYLOAD_BYTES, 63, maximum payload length in bytes.
- BEAT_BYTES, 1, bytes per output beat (1, 2, 4 or 8).
- LEN_W, $clog2(MAX_PAYLOAD_BYTES+1), width of the payload length field.
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_head  in  HEAD_BYTES*8  header; first byte on the wire is in the MSBs.
- i_payload  in  MAX_PAYLOAD_BYTES*8  payload, MSB-aligned; first byte is in the MSBs.
- i_payload_len  in  LEN_W  payload length in bytes; 0 sends a header-only frame.
- i_valid  in  1  a reply is presented.
- o_ready  out  1  the block accepts a reply this cycle.
- o_data  out  BEAT_BYTES*8  output beat; the earliest byte is in the MSBs.
- o_keep  out  BEAT_BYTES  byte-valid mask; o_keep[BEAT_BYTES-1] qualifies the MSB byte.
- o_valid  out  1  o_data, o_keep and o_last are valid.
- i_ready  in  1  downstream accepts the beat.
- o_last  out  1  final beat of the frame.
- o_len_err  out  1  one-cycle pulse: i_payload_len exceeded the maximum and was clamped.
- o_frame_cnt  out  16  count of completed frames; wraps at 2^16.

## Operation
- States: IDLE and SEND.
- Load happens when i_valid and o_ready are both high at a clock edge.
  - The shift register is loaded with {i_head, i_payload}, (HEAD_BYTES+MAX_PAYLOAD_BYTES)*8 bits.
  - The remaining-byte counter rem is loaded with HEAD_BYTES + min(i_payload_len, MAX_PAYLOAD_BYTES).
  - The state moves to SEND.
- If i_payload_len > MAX_PAYLOAD_BYTES at load: the length is clamped to MAX_PAYLOAD_BYTES and o_len_err pulses high in the next cycle.
- In SEND:
  - o_data is the top BEAT_BYTES*8 bits of the shift register.
  - o_valid = 1.
  - o_last = (rem <= BEAT_BYTES).
  - o_keep = all ones if rem >= BEAT_BYTES; otherwise the top rem bits are set and the rest are zero (contiguous from the MSB).
- On a beat handshake (o_valid & i_ready):
  - The shift register shifts left by BEAT_BYTES*8.
  - rem decrements by BEAT_BYTES.
  - If the beat was o_last: o_frame_cnt increments and the state returns to IDLE, unless a new load occurs in the same cycle.
- o_ready = (state == IDLE) | (o_valid & i_ready & o_last). This is a combinational path from i_ready, and it permits back-to-back frames with no bubble.
- Simultaneous last-beat handshake and load: the load takes priority. The state stays in SEND, and the new frame's first beat appears the next cycle.
- Bytes past rem in the final beat are don't-care but are driven from the shift register. Zeros are shifted in.
- Counter widths: rem uses $clog2(HEAD_BYTES+MAX_PAYLOAD_BYTES+1) bits. There is no underflow, because the final decrement is taken only with o_last.

## Timing
- Reset values: o_valid=0, o_last=0, o_keep=0, o_data=0, o_len_err=0, o_frame_cnt=0, state=IDLE. o_ready=1 as soon as reset deasserts.
- Reset asserted mid-frame: the frame is dropped immediately, with no o_last, and the counter is not incremented.
- Latency: a load at edge N gives the first beat valid after edge N.
- Frame length: ceil((HEAD_BYTES+len)/BEAT_BYTES) beats at full throughput.
- While o_valid=1 and i_ready=0, o_data, o_keep and o_last hold stable.
- Inputs i_head, i_payload and i_payload_len are sampled only at load. They may change freely afterwards.

## Test plan
- Defaults (BEAT=1): head bytes 0x01..0x2A, len=3, payload AA BB CC, i_ready=1.
  - 45 beats: 01..2A, AA, BB, CC.
  - o_last only on CC.
  - o_keep=1 on every beat.
  - o_frame_cnt=1.
- Defaults, len=0: 42 beats, 01..2A, with o_last on 0x2A.
- BEAT=4, len=3 (45 bytes): 12 beats.
  - Beat 0 = 0x01020304.
  - The last beat has o_keep=4'b1000 and MSB byte CC.
- Backpressure: i_ready toggles 1,0,0,1 pseudo-randomly.
  - The byte sequence is identical to the first scenario.
  - Outputs stay stable during stall cycles.
- Clamp: len=70.
  - o_len_err pulses once.
  - 42+63=105 beats are sent.
- Back-to-back and reset:
  - A second reply is presented with i_valid held.
    - The load happens on the last-beat cycle, with zero idle beats between the frames.
    - o_frame_cnt=2.
  - i_reset asserted at beat 10 of a new frame:
    - all outputs take their reset values in the same cycle.
    - o_frame_cnt=0.

Source files
------------

// File: rtl/ethernet_reply_stream_tx_if.sv
// Reply-in / beat-out bundle for the Ethernet reply serializer.
// slave is the serializer's side; master is the builder/MAC side.
interface ethernet_reply_stream_tx_if #(
    parameter int HEAD_BYTES        = 42,
    parameter int MAX_PAYLOAD_BYTES = 63,
    parameter int BEAT_BYTES        = 1,
    parameter int LEN_W             = $clog2(MAX_PAYLOAD_BYTES + 1)
);
    logic [HEAD_BYTES*8-1:0]        i_head;
    logic [MAX_PAYLOAD_BYTES*8-1:0] i_payload;
    logic [LEN_W-1:0]               i_payload_len;
    logic                           i_valid;
    logic                           o_ready;
    logic [BEAT_BYTES*8-1:0]        o_data;
    logic [BEAT_BYTES-1:0]          o_keep;
    logic                           o_valid;
    logic                           i_ready;
    logic                           o_last;

    modport slave (
        input  i_head, i_payload, i_payload_len, i_valid, i_ready,
        output o_ready, o_data, o_keep, o_valid, o_last
    );

    modport master (
        output i_head, i_payload, i_payload_len, i_valid, i_ready,
        input  o_ready, o_data, o_keep, o_valid, o_last
    );
endinterface

// File: rtl/ethernet_reply_stream_tx.sv
// Serializes one pre-built reply (header + variable payload) into a
// BEAT_BYTES-wide valid/ready stream with keep mask and end-of-frame marker.
module ethernet_reply_stream_tx #(
    parameter int HEAD_BYTES        = 42,
    parameter int MAX_PAYLOAD_BYTES = 63,
    parameter int BEAT_BYTES        = 1,
    parameter int LEN_W             = $clog2(MAX_PAYLOAD_BYTES + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    ethernet_reply_stream_tx_if.slave s_if,
    output logic                      o_len_err,
    output logic [15:0]               o_frame_cnt
);
    localparam int TOT_BYTES = HEAD_BYTES + MAX_PAYLOAD_BYTES;
    localparam int SR_W      = TOT_BYTES * 8;
    localparam int BEAT_W    = BEAT_BYTES * 8;
    localparam int REM_W     = $clog2(TOT_BYTES + 1);

    localparam logic [REM_W-1:0] BEAT_REM = REM_W'(BEAT_BYTES);
    localparam logic [REM_W-1:0] HEAD_REM = REM_W'(HEAD_BYTES);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD_BYTES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              len_err_q, len_err_d;

    logic                  sending;
    logic                  last;
    logic                  beat_fire;
    logic                  ready;
    logic                  load;
    logic                  len_over;
    logic [LEN_W-1:0]      len_clamped;
    logic [BEAT_BYTES-1:0] keep;

    // Keep mask: byte lane i (counted from the MSB) is live while rem covers it.
    always_comb begin
        keep = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            keep[BEAT_BYTES-1-i] = sending && (rem_q > REM_W'(i));
        end
    end

    always_comb begin
        sending     = (state_q == SEND);
        last        = sending && (rem_q <= BEAT_REM);
        beat_fire   = sending && s_if.i_ready;
        // Accepting on the last-beat handshake gives back-to-back frames.
        ready       = !sending || (beat_fire && last);
        load        = s_if.i_valid && ready;
        len_over    = (s_if.i_payload_len > MAX_LEN);
        len_clamped = len_over ? MAX_LEN : s_if.i_payload_len;

        state_d     = state_q;
        sr_d        = sr_q;
        rem_d       = rem_q;
        frame_cnt_d = frame_cnt_q;
        len_err_d   = 1'b0;

        if (beat_fire) begin
            sr_d = sr_q << BEAT_W;
            if (last) begin
                rem_d       = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = IDLE;
            end else begin
                rem_d = rem_q - BEAT_REM;
            end
        end

        // A load overrides the last-beat return to IDLE.
        if (load) begin
            sr_d      = {s_if.i_head, s_if.i_payload};
            rem_d     = HEAD_REM + REM_W'(len_clamped);
            state_d   = SEND;
            len_err_d = len_over;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            frame_cnt_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            frame_cnt_q <= frame_cnt_d;
            len_err_q   <= len_err_d;
        end
    end

    // Byte storage carries no reset; outputs are gated by state instead.
    always_ff @(posedge i_clk) begin
        sr_q <= sr_d;
    end

    assign s_if.o_ready  = ready;
    assign s_if.o_valid  = sending;
    assign s_if.o_last   = last;
    assign s_if.o_keep   = keep;
    assign s_if.o_data   = sending ? sr_q[SR_W-1 -: BEAT_W] : '0;
    assign o_len_err     = len_err_q;
    assign o_frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_ethernet_reply_stream_tx.sv
// Bench for ethernet_reply_stream_tx: a 1-byte-beat and a 4-byte-beat instance
// checked every cycle against a byte-queue model of the reply stream.
module tb_ethernet_reply_stream_tx;
    localparam int HB = 42;
    localparam int MP = 63;
    localparam int LW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [HB*8-1:0] head;
    logic [MP*8-1:0] payload;
    logic [LW-1:0]   len;
    logic            va = 1'b0;
    logic            vb = 1'b0;
    logic            rdy = 1'b1;
    bit              rnd = 1'b0;

    logic        lerr_a, lerr_b;
    logic [15:0] cnt_a, cnt_b;

    ethernet_reply_stream_tx_if #(.HEAD_BYTES(HB), .MAX_PAYLOAD_BYTES(MP), .BEAT_BYTES(1), .LEN_W(LW)) ifa ();
    ethernet_reply_stream_tx_if #(.HEAD_BYTES(HB), .MAX_PAYLOAD_BYTES(MP), .BEAT_BYTES(4), .LEN_W(LW)) ifb ();

    assign ifa.i_head        = head;
    assign ifa.i_payload     = payload;
    assign ifa.i_payload_len = len;
    assign ifa.i_valid       = va;
    assign ifa.i_ready       = rdy;
    assign ifb.i_head        = head;
    assign ifb.i_payload     = payload;
    assign ifb.i_payload_len = len;
    assign ifb.i_valid       = vb;
    assign ifb.i_ready       = rdy;

    ethernet_reply_stream_tx #(.HEAD_BYTES(HB), .MAX_PAYLOAD_BYTES(MP), .BEAT_BYTES(1), .LEN_W(LW)) dut_a (
        .i_clk(clk), .i_reset(rst), .s_if(ifa.slave), .o_len_err(lerr_a), .o_frame_cnt(cnt_a));
    ethernet_reply_stream_tx #(.HEAD_BYTES(HB), .MAX_PAYLOAD_BYTES(MP), .BEAT_BYTES(4), .LEN_W(LW)) dut_b (
        .i_clk(clk), .i_reset(rst), .s_if(ifb.slave), .o_len_err(lerr_b), .o_frame_cnt(cnt_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the bytes still owed on the wire for the current frame, per instance.
    byte unsigned mq[2][$];
    int           mcnt[2];
    logic         mlerr[2];
    int           loads[2];
    int           beats[2];
    logic [63:0]  first_d[2];
    logic [63:0]  last_d[2];
    logic [7:0]   last_k[2];
    bit           in_fr[2];
    int           lerr_pulses[2];
    int           idle_cyc[2];

    task automatic step(input int id, input int bb, input logic iv, input logic v,
                        input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic r, input logic le, input logic [15:0] c);
        int          sz;
        int          n;
        int          plen;
        logic        exp_rdy;
        logic [7:0]  ek;
        string       p;
        p  = (id == 0) ? "A" : "B";
        sz = mq[id].size();
        if (rst) begin
            chk({p, "_rst_valid"}, 64'(v), 64'(0));
            chk({p, "_rst_data"},  d, 64'(0));
            chk({p, "_rst_keep"},  64'(k), 64'(0));
            chk({p, "_rst_last"},  64'(l), 64'(0));
            chk({p, "_rst_lerr"},  64'(le), 64'(0));
            chk({p, "_rst_cnt"},   64'(c), 64'(0));
            mq[id].delete();
            mcnt[id]  = 0;
            mlerr[id] = 1'b0;
            in_fr[id] = 1'b0;
            return;
        end
        exp_rdy = (sz == 0) || (rdy && sz <= bb);
        chk({p, "_valid"}, 64'(v), 64'(sz != 0));
        chk({p, "_ready"}, 64'(r), 64'(exp_rdy));
        chk({p, "_len_err"}, 64'(le), 64'(mlerr[id]));
        chk({p, "_frame_cnt"}, 64'(c), 64'(16'(mcnt[id])));
        if (sz != 0) begin
            chk({p, "_last"}, 64'(l), 64'(sz <= bb));
            ek = '0;
            for (int i = 0; i < bb; i++) if (i < sz) ek[bb-1-i] = 1'b1;
            chk({p, "_keep"}, 64'(k), 64'(ek));
            for (int i = 0; i < bb; i++)
                if (i < sz) chk($sformatf("%s_byte%0d", p, i), 64'(d[(bb-1-i)*8 +: 8]), 64'(mq[id][i]));
        end
        if (le) lerr_pulses[id]++;
        if (!v) idle_cyc[id]++;

        // Advance the model across the coming clock edge.
        if (sz != 0 && rdy) begin
            if (!in_fr[id]) begin
                in_fr[id]   = 1'b1;
                beats[id]   = 0;
                first_d[id] = d;
            end
            beats[id]++;
            n = (sz < bb) ? sz : bb;
            repeat (n) void'(mq[id].pop_front());
            if (mq[id].size() == 0) begin
                mcnt[id]++;
                in_fr[id]  = 1'b0;
                last_d[id] = d;
                last_k[id] = k;
            end
        end
        mlerr[id] = 1'b0;
        if (iv && exp_rdy) begin
            loads[id]++;
            plen = (int'(len) > MP) ? MP : int'(len);
            mlerr[id] = (int'(len) > MP);
            for (int b = 0; b < HB; b++) mq[id].push_back(head[(HB-1-b)*8 +: 8]);
            for (int b = 0; b < plen; b++) mq[id].push_back(payload[(MP-1-b)*8 +: 8]);
        end
    endtask

    always @(negedge clk) begin
        step(0, 1, va, ifa.o_valid, 64'(ifa.o_data), 8'(ifa.o_keep), ifa.o_last, ifa.o_ready, lerr_a, cnt_a);
        step(1, 4, vb, ifb.o_valid, 64'(ifb.o_data), 8'(ifb.o_keep), ifb.o_last, ifb.o_ready, lerr_b, cnt_b);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [HB*8-1:0] dhead;
    logic [MP*8-1:0] dpay;
    logic [HB*8-1:0] rhead;
    logic [MP*8-1:0] rpay;

    task automatic send_frame(input logic [HB*8-1:0] h, input logic [MP*8-1:0] pl, input int l);
        head    = h;
        payload = pl;
        len     = LW'(l);
        va = 1'b1;
        vb = 1'b1;
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
        for (int b = 0; b < HB; b++) head[b*8 +: 8] = 8'($urandom);
        for (int b = 0; b < MP; b++) payload[b*8 +: 8] = 8'($urandom);
        len = LW'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((mq[0].size() != 0 || mq[1].size() != 0) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("wait_idle_timeout", 64'(t >= 3000), 64'(0));
    endtask

    initial begin
        int c0;
        int p0, p1;
        int idle0;
        int t;
        for (int b = 0; b < HB; b++) dhead[(HB-1-b)*8 +: 8] = 8'(b + 1);
        dpay = '0;
        dpay[MP*8-1 -: 24] = 24'hAABBCC;
        head = dhead;
        payload = dpay;
        len = 7'd3;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Defaults, len=3, full throughput.
        send_frame(dhead, dpay, 3);
        wait_idle();
        chk("S1_A_beats", 64'(beats[0]), 64'(45));
        chk("S1_A_first", first_d[0], 64'h01);
        chk("S1_A_last_data", last_d[0], 64'hCC);
        chk("S1_A_last_keep", 64'(last_k[0]), 64'h1);
        chk("S1_A_cnt", 64'(cnt_a), 64'(1));
        chk("S1_A_lerr", 64'(lerr_pulses[0]), 64'(0));
        chk("S1_B_beats", 64'(beats[1]), 64'(12));
        chk("S1_B_first", first_d[1], 64'h01020304);
        chk("S1_B_last_keep", 64'(last_k[1]), 64'h8);
        chk("S1_B_last_msb", 64'(last_d[1][31:24]), 64'hCC);
        chk("S1_B_cnt", 64'(cnt_b), 64'(1));

        // Header-only frame.
        send_frame(dhead, dpay, 0);
        wait_idle();
        chk("S2_A_beats", 64'(beats[0]), 64'(42));
        chk("S2_A_last_data", last_d[0], 64'h2A);
        chk("S2_B_beats", 64'(beats[1]), 64'(11));
        chk("S2_B_last_keep", 64'(last_k[1]), 64'hC);
        chk("S2_B_last_top", 64'(last_d[1][31:16]), 64'h292A);

        // Backpressure on the default frame.
        rnd = 1'b1;
        send_frame(dhead, dpay, 3);
        wait_idle();
        rnd = 1'b0;
        chk("S3_A_beats", 64'(beats[0]), 64'(45));
        chk("S3_A_last_data", last_d[0], 64'hCC);
        chk("S3_B_beats", 64'(beats[1]), 64'(12));

        // Over-length payload is clamped.
        p0 = lerr_pulses[0];
        p1 = lerr_pulses[1];
        send_frame(dhead, dpay, 70);
        wait_idle();
        chk("S4_A_beats", 64'(beats[0]), 64'(105));
        chk("S4_B_beats", 64'(beats[1]), 64'(27));
        chk("S4_B_last_keep", 64'(last_k[1]), 64'h8);
        chk("S4_A_lerr_pulses", 64'(lerr_pulses[0] - p0), 64'(1));
        chk("S4_B_lerr_pulses", 64'(lerr_pulses[1] - p1), 64'(1));

        // Random replies under random backpressure.
        rnd = 1'b1;
        for (int f = 0; f < 10; f++) begin
            for (int b = 0; b < HB; b++) rhead[b*8 +: 8] = 8'($urandom);
            for (int b = 0; b < MP; b++) rpay[b*8 +: 8] = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_frame(rhead, rpay, int'($urandom_range(0, 70)));
            wait_idle();
        end
        rnd = 1'b0;

        // Back-to-back: i_valid held across two replies.
        c0 = int'(cnt_a);
        p0 = loads[0];
        p1 = loads[1];
        idle0 = -1;
        head = dhead;
        payload = dpay;
        len = 7'd3;
        va = 1'b1;
        vb = 1'b1;
        t = 0;
        while ((va || vb) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
            if (idle0 < 0 && loads[0] == p0 + 1) idle0 = idle_cyc[0];
            if (loads[0] >= p0 + 2) va = 1'b0;
            if (loads[1] >= p1 + 2) vb = 1'b0;
        end
        chk("S6_load_timeout", 64'(t >= 500), 64'(0));
        va = 1'b0;
        vb = 1'b0;
        wait_idle();
        chk("S6_A_idle_between", 64'(idle_cyc[0] - idle0), 64'(0));
        chk("S6_A_cnt_delta", 64'(16'(cnt_a - 16'(c0))), 64'(2));

        // Reset in the middle of a frame.
        send_frame(dhead, dpay, 3);
        t = 0;
        while (beats[0] != 10 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("S7_beat10_timeout", 64'(t >= 200), 64'(0));
        rst = 1'b1;
        #1;
        chk("S7_A_valid", 64'(ifa.o_valid), 64'(0));
        chk("S7_A_last", 64'(ifa.o_last), 64'(0));
        chk("S7_A_keep", 64'(ifa.o_keep), 64'(0));
        chk("S7_A_data", 64'(ifa.o_data), 64'(0));
        chk("S7_A_cnt", 64'(cnt_a), 64'(0));
        chk("S7_B_valid", 64'(ifb.o_valid), 64'(0));
        chk("S7_B_cnt", 64'(cnt_b), 64'(0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("S7_A_ready_after_reset", 64'(ifa.o_ready), 64'(1));
        @(posedge clk);
        #1;
        send_frame(dhead, dpay, 3);
        wait_idle();
        chk("S7_A_cnt_after", 64'(cnt_a), 64'(1));
        chk("S7_A_beats_after", 64'(beats[0]), 64'(45));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
